// File: rtl/uart_rx_intr.sv
// uart_rx_intr: 8N1 UART receiver with a first-word-fall-through receive FIFO
// and a level receive interrupt (feeds the UART pending bit in the CSR file).
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with parity_err flag).
// Ports:
//   clk, rst        core clock, asynchronous active-low reset
//   rx_i            serial line (asynchronous, idle high)
//   rd_en           pop FIFO head (ignored when empty)
//   rd_data         FIFO head byte, 8'h00 when empty
//   rx_valid        FIFO non-empty
//   intr_en         receive-interrupt enable
//   rx_intr         rx_valid & intr_en (combinational)
//   err_clr         clears sticky error flags
//   frame_err       sticky: stop bit sampled low
//   overrun_err     sticky: byte completed while FIFO full
//   parity_err      sticky: even-parity mismatch (UART_RX_PARITY_EN only)
//   busy            receiver FSM not idle
module uart_rx_intr #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    input  logic       intr_en,
    output logic       rx_intr,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W   = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic             frame_err_q, frame_err_d;
    logic             overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
    logic             parity_set;
`endif

    logic rx_s, stop_sample, byte_ok, push, pop, full, empty;

    assign rx_s  = sync2_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Next-state logic: receiver FSM, FIFO and sticky flags
    always_comb begin
        state_d     = state_q;
        sync1_d     = rx_i;
        sync2_d     = sync1_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        parity_set  = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                // armed gate: a held-low line must go high before the next start
                if (armed_q && !rx_s) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    armed_d   = 1'b0;
                end else if (rx_s) begin
                    armed_d = 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(HALF_M1)) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(FULL_M1)) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_W'(FULL_M1)) begin
                    cnt_d      = '0;
                    par_bad_d  = ^{shreg_q, rx_s};
                    parity_set = ^{shreg_q, rx_s};
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_W'(FULL_M1)) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_RX_PARITY_EN
        byte_ok = stop_sample && rx_s && !par_bad_q;
`else
        byte_ok = stop_sample && rx_s;
`endif
        // a pop in the push cycle frees the slot, so a full FIFO still accepts
        pop  = rd_en && !empty;
        push = byte_ok && (!full || pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = shreg_q;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        // set wins over a simultaneous clear
        frame_err_d   = (stop_sample && !rx_s) || (frame_err_q && !err_clr);
        overrun_err_d = (byte_ok && full && !pop) || (overrun_err_q && !err_clr);
`ifdef UART_RX_PARITY_EN
        parity_err_d  = parity_set || (parity_err_q && !err_clr);
`endif
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_q         <= '{default: 8'h00};
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rd_data     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid    = !empty;
    assign rx_intr     = rx_valid && intr_en;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_intr.sv
// tb_uart_rx_intr: self-checking bench for uart_rx_intr (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Directed vectors from a table, hand-written corner sequences and a randomized
// run checked against a queue-based model of the receiver.
module tb_uart_rx_intr;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // edges from the start-bit edge to the stop-bit sample: 2 sync + 1 detect,
    // half a bit to mid-start, then one bit period per remaining bit
    localparam int PUSH_EDGE = 3 + CPB / 2 + (NBITS - 1) * CPB;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       clr_before;
        logic [7:0] exp_head;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_oerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_i = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       intr_en = 1'b1;
    logic       rx_intr;
    logic       err_clr = 1'b0;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic pre_valid, post_valid, post_busy;

    uart_rx_intr #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rx_valid   (rx_valid),
        .intr_en    (intr_en),
        .rx_intr    (rx_intr),
        .err_clr    (err_clr),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Send one frame; optionally hold rd_en exactly during the push cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pop_on_push);
        logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
        bits = {stop_b, d, 1'b0};
`endif
        rx_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rx_i = bits[0];
        for (int c = 1; c <= NBITS * CPB; c++) begin
            @(posedge clk);
            #1;
            if (c < NBITS * CPB) rx_i = bits[c / CPB];
            else rx_i = 1'b1;
            if (c == PUSH_EDGE - 1) begin
                pre_valid = rx_valid;
                rd_en     = pop_on_push;
            end
            if (c == PUSH_EDGE) begin
                rd_en      = 1'b0;
                post_valid = rx_valid;
                post_busy  = busy;
            end
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic clr_one();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        vec_t       tbl [6];
        logic [7:0] q [$];
        logic       m_ferr, m_oerr, m_perr, sb, pbad;
        logic [7:0] d, exp_head;
        int         npop;

        tbl[0] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h02, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h03, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h04, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h05, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_intr", rx_intr, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_oerr", overrun_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // single byte, latency and interrupt
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_pre_valid", pre_valid, 0);
        chk("a5_post_valid", post_valid, 1);
        chk("a5_post_busy", post_busy, 0);
        chk("a5_rd_data", rd_data, 8'hA5);
        chk("a5_intr", rx_intr, 1);
        pop_one();
        chk("a5_pop_valid", rx_valid, 0);
        chk("a5_pop_intr", rx_intr, 0);

        // 5-clock low glitch on idle line
        repeat (4) @(posedge clk);
        #1;
        rx_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("glitch_busy", busy, 1);
        rx_i = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_idle", busy, 0);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_ferr", frame_err, 0);
        chk("glitch_oerr", overrun_err, 0);

        // framing error then fill past capacity
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr_before) begin
                clr_one();
                chk("err_clr_ferr", frame_err, 0);
            end
            send_frame(tbl[i].data, tbl[i].stop, 1'b0);
            chk($sformatf("tbl%0d_head", i), rd_data, tbl[i].exp_head);
            chk($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_ferr", i), frame_err, tbl[i].exp_ferr);
            chk($sformatf("tbl%0d_oerr", i), overrun_err, tbl[i].exp_oerr);
        end
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_read%0d", i), rd_data, i);
            pop_one();
        end
        chk("ovr_empty", rx_valid, 0);
        chk("ovr_empty_data", rd_data, 0);
        pop_one();
        chk("empty_pop_valid", rx_valid, 0);
        clr_one();
        chk("ovr_clr", overrun_err, 0);

        // full FIFO with a pop in the push cycle
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1);
        chk("pp_pre_valid", pre_valid, 1);
        chk("pp_oerr", overrun_err, 0);
        exp_head = 8'h22;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_read%0d", i), rd_data, exp_head);
            pop_one();
            exp_head = exp_head + 8'h11;
        end
        chk("pp_empty", rx_valid, 0);

        // randomized frames against a queue model
        m_ferr = 1'b0;
        m_oerr = 1'b0;
        m_perr = 1'b0;
        for (int n = 0; n < 14; n++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            pbad = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flip = ($urandom_range(0, 4) == 0);
            pbad = par_flip;
`endif
            send_frame(d, sb, 1'b0);
            if (pbad) m_perr = 1'b1;
            if (!sb) m_ferr = 1'b1;
            if (sb && !pbad) begin
                if (q.size() == DEPTH) m_oerr = 1'b1;
                else q.push_back(d);
            end
            chk($sformatf("rnd%0d_ferr", n), frame_err, m_ferr);
            chk($sformatf("rnd%0d_oerr", n), overrun_err, m_oerr);
`ifdef UART_RX_PARITY_EN
            chk($sformatf("rnd%0d_perr", n), parity_err, m_perr);
`endif
            chk($sformatf("rnd%0d_valid", n), rx_valid, q.size() != 0);
            if ($urandom_range(0, 3) == 0) begin
                clr_one();
                m_ferr = 1'b0;
                m_oerr = 1'b0;
                m_perr = 1'b0;
            end
            npop = $urandom_range(0, 3);
            for (int k = 0; k < npop; k++) begin
                intr_en = 1'($urandom_range(0, 1));
                #1;
                chk($sformatf("rnd%0d_intr", n), rx_intr, (q.size() != 0) && intr_en);
                chk($sformatf("rnd%0d_head", n), rd_data, (q.size() != 0) ? q[0] : 8'h00);
                pop_one();
                if (q.size() != 0) void'(q.pop_front());
            end
        end
        intr_en = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        while (q.size() != 0) begin
            chk("drain_head", rd_data, q[0]);
            pop_one();
            void'(q.pop_front());
        end
        chk("drain_empty", rx_valid, 0);

        // reset in the middle of a frame
        send_frame(8'h77, 1'b1, 1'b0);
        chk("pre_rst_head", rd_data, 8'h77);
        rx_i = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        chk("post_rst_valid", rx_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ferr", frame_err, 0);
        chk("post_rst_oerr", overrun_err, 0);
        send_frame(8'h12, 1'b1, 1'b0);
        chk("rst_rx_head", rd_data, 8'h12);
        pop_one();
        chk("rst_rx_only", rx_valid, 0);

`ifdef UART_RX_PARITY_EN
        // 0x07 with parity bit 0 breaks even parity
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_err", parity_err, 1);
        chk("par_drop", rx_valid, 0);
        chk("par_ferr", frame_err, 0);
        clr_one();
        chk("par_clr", parity_err, 0);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_ok_head", rd_data, 8'h07);
        chk("par_ok_err", parity_err, 0);
        pop_one();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
